// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared fetch-stage constants, FSM encoding and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Fetch-stage bus: hazard/redirect controls, imem port, IF/ID.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  stall;
    logic                  flush;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic [ADDR_WIDTH-1:0] if_id_pc;
    logic [ADDR_WIDTH-1:0] if_id_pc_plus4;
    logic [DATA_WIDTH-1:0] if_id_instr;
    logic                  if_id_valid;
    logic                  if_id_misaligned;
    logic [31:0]           fetch_count;

    // master = the fetch stage itself
    modport master (
        input  stall, flush, branch_taken, branch_target, instr,
        output instr_addr, if_id_pc, if_id_pc_plus4, if_id_instr,
               if_id_valid, if_id_misaligned, fetch_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, instr,
        input  instr_addr, if_id_pc, if_id_pc_plus4, if_id_instr,
               if_id_valid, if_id_misaligned, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with load / bubble / hold controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  load,
    input  wire logic                  bubble,
    input  wire logic                  hold,
    input  wire logic [ADDR_WIDTH-1:0] pc_d,
    input  wire logic [DATA_WIDTH-1:0] instr_d,
    input  wire logic                  misaligned_d,
    output logic      [ADDR_WIDTH-1:0] pc_q,
    output logic      [ADDR_WIDTH-1:0] pc_plus4_q,
    output logic      [DATA_WIDTH-1:0] instr_q,
    output logic                       valid_q,
    output logic                       misaligned_q
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_valid;
    logic                  r_misaligned;

    // A bubble only kills the payload; pc/pc_plus4 keep their last value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_pc_plus4   <= ADDR_WIDTH'(4);
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (hold) begin
            r_pc         <= r_pc;
        end else if (load) begin
            r_pc         <= pc_d;
            r_pc_plus4   <= pc_d + ADDR_WIDTH'(4);
            r_instr      <= instr_d;
            r_valid      <= 1'b1;
            r_misaligned <= misaligned_d;
        end else if (bubble) begin
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end
    end

    assign pc_q         = r_pc;
    assign pc_plus4_q   = r_pc_plus4;
    assign instr_q      = r_instr;
    assign valid_q      = r_valid;
    assign misaligned_q = r_misaligned;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction fetch: PC, redirect/trap FSM, fetch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = C_RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = C_NOP_INSTR
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_stage_if.master bus
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [31:0]           r_fetch_count;

    logic                  w_load;
    logic                  w_bubble;
    logic                  w_hold;
    logic                  w_count_inc;
    logic [ADDR_WIDTH-1:0] w_ld_pc;
    logic [DATA_WIDTH-1:0] w_ld_instr;
    logic                  w_ld_misaligned;
    logic                  w_target_misaligned;

    assign w_target_misaligned = is_misaligned(bus.branch_target[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_load          = 1'b0;
        w_bubble        = 1'b0;
        w_hold          = 1'b0;
        w_count_inc     = 1'b0;
        w_ld_pc         = r_pc;
        w_ld_instr      = bus.instr;
        w_ld_misaligned = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
                w_hold       = 1'b1;
            end
            ST_RUN: begin
                if (bus.branch_taken) begin
                    if (w_target_misaligned) begin
                        // Trap marker carries the offending target; pc stays put
                        w_load          = 1'b1;
                        w_ld_pc         = bus.branch_target;
                        w_ld_instr      = NOP_INSTR;
                        w_ld_misaligned = 1'b1;
                        w_state_next    = ST_TRAP;
                    end else begin
                        w_pc_next = bus.branch_target;
                        w_bubble  = 1'b1;
                    end
                end else if (bus.flush) begin
                    w_bubble = 1'b1;
                end else if (bus.stall) begin
                    w_hold = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_pc_next   = r_pc + ADDR_WIDTH'(4);
                    w_count_inc = 1'b1;
                end
            end
            ST_TRAP: begin
                if (bus.branch_taken && w_target_misaligned) begin
                    w_load          = 1'b1;
                    w_ld_pc         = bus.branch_target;
                    w_ld_instr      = NOP_INSTR;
                    w_ld_misaligned = 1'b1;
                end else if (bus.branch_taken) begin
                    w_pc_next    = bus.branch_target;
                    w_bubble     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
                w_hold       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_count_inc) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (w_load),
        .bubble       (w_bubble),
        .hold         (w_hold),
        .pc_d         (w_ld_pc),
        .instr_d      (w_ld_instr),
        .misaligned_d (w_ld_misaligned),
        .pc_q         (bus.if_id_pc),
        .pc_plus4_q   (bus.if_id_pc_plus4),
        .instr_q      (bus.if_id_instr),
        .valid_q      (bus.if_id_valid),
        .misaligned_q (bus.if_id_misaligned)
    );

    assign bus.instr_addr  = r_pc;
    assign bus.fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed vector bench for fetch_stage with a combinational imem.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.instr = mem(bus.instr_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("instr_addr",       idx, bus.instr_addr,            v.addr);
        chk("if_id_pc",         idx, bus.if_id_pc,              v.pc);
        chk("if_id_pc_plus4",   idx, bus.if_id_pc_plus4,        v.pc4);
        chk("if_id_instr",      idx, bus.if_id_instr,           v.ins);
        chk("if_id_valid",      idx, {31'd0, bus.if_id_valid},  {31'd0, v.valid});
        chk("if_id_misaligned", idx, {31'd0, bus.if_id_misaligned}, {31'd0, v.mis});
        chk("fetch_count",      idx, bus.fetch_count,           v.cnt);
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                                input logic [31:0] a, input logic [31:0] p, input logic [31:0] p4,
                                input logic [31:0] i, input logic v, input logic m, input logic [31:0] c);
        vec_t r;
        r.stall = s; r.flush = f; r.br = b; r.tgt = t;
        r.addr = a; r.pc = p; r.pc4 = p4; r.ins = i; r.valid = v; r.mis = m; r.cnt = c;
        return r;
    endfunction

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t);
        bus.stall = s; bus.flush = f; bus.branch_taken = b; bus.branch_target = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[23];
    vec_t exp_v;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        //               stl  fl   br   tgt           addr          pc            pc4           instr             v    m    cnt
        vecs[0]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h00, 32'h00, 32'h04, C_NOP,        1'b0,1'b0,32'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h04, 32'h00, 32'h04, mem(32'h00),  1'b1,1'b0,32'd1);
        vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h08, 32'h04, 32'h08, mem(32'h04),  1'b1,1'b0,32'd2);
        vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h0C, 32'h08, 32'h0C, mem(32'h08),  1'b1,1'b0,32'd3);
        vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h10, 32'h0C, 32'h10, mem(32'h0C),  1'b1,1'b0,32'd4);
        vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,   32'h10, 32'h0C, 32'h10, mem(32'h0C),  1'b1,1'b0,32'd4);
        vecs[6]  = mk(1'b1,1'b0,1'b0,32'h0,   32'h10, 32'h0C, 32'h10, mem(32'h0C),  1'b1,1'b0,32'd4);
        vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h14, 32'h10, 32'h14, mem(32'h10),  1'b1,1'b0,32'd5);
        vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0,   32'h18, 32'h14, 32'h18, mem(32'h14),  1'b1,1'b0,32'd6);
        vecs[9]  = mk(1'b1,1'b0,1'b1,32'h40,  32'h40, 32'h14, 32'h18, C_NOP,        1'b0,1'b0,32'd6);
        vecs[10] = mk(1'b0,1'b0,1'b0,32'h0,   32'h44, 32'h40, 32'h44, mem(32'h40),  1'b1,1'b0,32'd7);
        vecs[11] = mk(1'b0,1'b0,1'b1,32'h20,  32'h20, 32'h40, 32'h44, C_NOP,        1'b0,1'b0,32'd7);
        vecs[12] = mk(1'b0,1'b1,1'b0,32'h0,   32'h20, 32'h40, 32'h44, C_NOP,        1'b0,1'b0,32'd7);
        vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,   32'h24, 32'h20, 32'h24, mem(32'h20),  1'b1,1'b0,32'd8);
        vecs[14] = mk(1'b0,1'b0,1'b1,32'h42,  32'h24, 32'h42, 32'h46, C_NOP,        1'b1,1'b1,32'd8);
        vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,   32'h24, 32'h42, 32'h46, C_NOP,        1'b0,1'b0,32'd8);
        vecs[16] = mk(1'b1,1'b0,1'b0,32'h0,   32'h24, 32'h42, 32'h46, C_NOP,        1'b0,1'b0,32'd8);
        vecs[17] = mk(1'b0,1'b0,1'b1,32'h51,  32'h24, 32'h51, 32'h55, C_NOP,        1'b1,1'b1,32'd8);
        vecs[18] = mk(1'b1,1'b1,1'b0,32'h0,   32'h24, 32'h51, 32'h55, C_NOP,        1'b0,1'b0,32'd8);
        vecs[19] = mk(1'b0,1'b0,1'b1,32'h80,  32'h80, 32'h51, 32'h55, C_NOP,        1'b0,1'b0,32'd8);
        vecs[20] = mk(1'b0,1'b0,1'b0,32'h0,   32'h84, 32'h80, 32'h84, mem(32'h80),  1'b1,1'b0,32'd9);
        vecs[21] = mk(1'b0,1'b1,1'b1,32'h100, 32'h100,32'h80, 32'h84, C_NOP,        1'b0,1'b0,32'd9);
        vecs[22] = mk(1'b0,1'b0,1'b0,32'h0,   32'h104,32'h100,32'h104,mem(32'h100), 1'b1,1'b0,32'd10);

        step();
        step();
        exp_v = mk(1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 32'h4, C_NOP, 1'b0,1'b0,32'd0);
        chk_all(-1, exp_v);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
            step();
            chk_all(i, vecs[i]);
        end

        // Enter TRAP, then reset while stalled: everything returns to reset values
        drive(1'b0, 1'b0, 1'b1, 32'h3);
        step();
        exp_v = mk(1'b0,1'b0,1'b0,32'h0, 32'h104, 32'h3, 32'h7, C_NOP, 1'b1,1'b1,32'd10);
        chk_all(100, exp_v);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        exp_v = mk(1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 32'h4, C_NOP, 1'b0,1'b0,32'd0);
        chk_all(101, exp_v);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_all(102, exp_v);
        step();
        exp_v = mk(1'b0,1'b0,1'b0,32'h0, 32'h4, 32'h0, 32'h4, mem(32'h0), 1'b1,1'b0,32'd1);
        chk_all(103, exp_v);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        exp_v = mk(1'b0,1'b0,1'b0,32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4, C_NOP, 1'b0,1'b0,32'd1);
        chk_all(104, exp_v);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        exp_v = mk(1'b0,1'b0,1'b0,32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, mem(32'hFFFF_FFFC), 1'b1,1'b0,32'd2);
        chk_all(105, exp_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
